// File: rtl/riscv_perf_pkg.sv
// Shared definitions for the RI5CY performance-counter unit.
//   - CSR operation encodings (same values as the core's CSR file)
//   - CSR address map of the unit
//   - CTRL bit positions
//   - perf_csr_apply: read-modify-write helper for WRITE/SET/CLEAR
package riscv_perf_pkg;

    localparam logic [1:0] CSR_OP_NONE  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    localparam logic [11:0] PERF_CTRL    = 12'h7A0;
    localparam logic [11:0] PERF_INHIBIT = 12'h7A1;
    localparam logic [11:0] PERF_OVF     = 12'h7A2;
    localparam logic [11:0] PERF_IRQEN   = 12'h7A3;
    localparam logic [11:0] PERF_CNT_LO  = 12'h780;
    localparam logic [11:0] PERF_CNT_HI  = 12'h7C0;
    localparam logic [11:0] PERF_EVTSEL  = 12'h7E0;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_SAT_BIT = 1;

    function automatic logic [31:0] perf_csr_apply(input logic [1:0]  op,
                                                   input logic [31:0] old,
                                                   input logic [31:0] wdata);
        logic [31:0] res;
        case (op)
            CSR_OP_WRITE: res = wdata;
            CSR_OP_SET:   res = old | wdata;
            CSR_OP_CLEAR: res = old & ~wdata;
            default:      res = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/riscv_perf_cnt_slice.sv
// One performance counter: counter register, event selector, registered
// increment request and the overflow-set pulse for the parent's OVF register.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   count_en_i      global enable and not inhibited
//   sat_i           1: hold at all-ones on overflow, 0: wrap to zero
//   evt_i           event lines
//   lo_we_i/hi_we_i write counter bits [31:0] / [CNT_WIDTH-1:32]
//   sel_we_i        write event selector
//   wdata_i         already-merged CSR write value
//   cnt_lo_o/hi_o   counter words, zero-extended
//   evtsel_o        current event selector
//   ovf_set_o       counter overflows at the coming edge
module riscv_perf_cnt_slice #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned N_EVENTS  = 16,
    parameter int unsigned EVT_SEL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 count_en_i,
    input  logic                 sat_i,
    input  logic [N_EVENTS-1:0]  evt_i,
    input  logic                 lo_we_i,
    input  logic                 hi_we_i,
    input  logic                 sel_we_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          cnt_lo_o,
    output logic [31:0]          cnt_hi_o,
    output logic [EVT_SEL_W-1:0] evtsel_o,
    output logic                 ovf_set_o
);

    localparam int unsigned EVT_PAD = 1 << EVT_SEL_W;
    localparam logic [EVT_SEL_W:0] N_EVT_L = (EVT_SEL_W + 1)'(N_EVENTS);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_wr;
    logic [EVT_SEL_W-1:0] evtsel_q, evtsel_d;
    logic                 inc_q, inc_d;
    logic [EVT_PAD-1:0]   evt_pad;
    logic                 evt_in_range;
    logic                 unused_wdata;

    // Pad so every selector value indexes a real bit; range check still gates it.
    assign evt_pad      = EVT_PAD'(evt_i);
    assign evt_in_range = {1'b0, evtsel_q} < N_EVT_L;
    assign unused_wdata = ^wdata_i;

    always_comb begin
        inc_d = 1'b0;
        if (evt_in_range) begin
            inc_d = count_en_i & evt_pad[evtsel_q];
        end
    end

    if (CNT_WIDTH > 32) begin : g_wide
        assign cnt_lo_o = cnt_q[31:0];
        assign cnt_hi_o = 32'(cnt_q[CNT_WIDTH-1:32]);
        always_comb begin
            cnt_wr = cnt_q;
            if (lo_we_i) cnt_wr[31:0] = wdata_i;
            if (hi_we_i) cnt_wr[CNT_WIDTH-1:32] = wdata_i[CNT_WIDTH-33:0];
        end
    end else begin : g_narrow
        assign cnt_lo_o = 32'(cnt_q);
        assign cnt_hi_o = '0;
        always_comb begin
            cnt_wr = cnt_q;
            if (lo_we_i) cnt_wr = wdata_i[CNT_WIDTH-1:0];
        end
    end

    // A CSR write to either word wins over a pending increment; that increment is lost.
    always_comb begin
        cnt_d     = cnt_q;
        ovf_set_o = 1'b0;
        if (lo_we_i | hi_we_i) begin
            cnt_d = cnt_wr;
        end else if (inc_q) begin
            if (&cnt_q) begin
                ovf_set_o = 1'b1;
                cnt_d     = sat_i ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign evtsel_d = sel_we_i ? wdata_i[EVT_SEL_W-1:0] : evtsel_q;
    assign evtsel_o = evtsel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            evtsel_q <= '0;
            inc_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            evtsel_q <= evtsel_d;
            inc_q    <= inc_d;
        end
    end

endmodule

// File: rtl/riscv_perf_counter_unit.sv
// Hardware performance-monitor unit beside the RI5CY CSR file.
// Holds CTRL {saturate, enable}, INHIBIT, sticky OVF and (optionally) IRQEN,
// decodes the CSR address map and muxes read data; counters live in slices.
// Optional feature macro: PERF_OVF_IRQ_EN adds IRQEN at 0x7A3 and a registered
// overflow interrupt; without it 0x7A3 is unmapped and perf_irq_o is 0.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   csr_access_i        CSR access qualifier
//   csr_addr_i          CSR address
//   csr_wdata_i         CSR write operand
//   csr_op_i            CSR operation (NONE/WRITE/SET/CLEAR)
//   csr_rdata_o         read data, 0 without a hit
//   csr_hit_o           access targets this unit
//   evt_i               event lines, counted every cycle high
//   ovf_o               sticky overflow flags
//   perf_irq_o          overflow interrupt (level)
module riscv_perf_counter_unit
    import riscv_perf_pkg::*;
#(
    parameter int unsigned N_COUNTERS = 4,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned N_EVENTS   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csr_access_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [31:0]           csr_wdata_i,
    input  logic [1:0]            csr_op_i,
    output logic [31:0]           csr_rdata_o,
    output logic                  csr_hit_o,
    input  logic [N_EVENTS-1:0]   evt_i,
    output logic [N_COUNTERS-1:0] ovf_o,
    output logic                  perf_irq_o
);

    localparam int unsigned EVT_SEL_W = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1;

    logic [1:0]            ctrl_q, ctrl_d;
    logic [N_COUNTERS-1:0] inhibit_q, inhibit_d;
    logic [N_COUNTERS-1:0] ovf_q, ovf_d;
    logic [N_COUNTERS-1:0] ovf_set;

    logic [31:0]           cnt_lo [N_COUNTERS];
    logic [31:0]           cnt_hi [N_COUNTERS];
    logic [EVT_SEL_W-1:0]  evtsel [N_COUNTERS];

    logic                  addr_hit;
    logic [31:0]           rd_data;
    logic                  sel_ctrl, sel_inhibit, sel_ovf;
    logic [N_COUNTERS-1:0] sel_lo, sel_hi, sel_evt;
    logic                  csr_we;
    logic [31:0]           wr_val;
    logic                  unused_wr_val;

`ifdef PERF_OVF_IRQ_EN
    logic                  sel_irqen;
    logic [N_COUNTERS-1:0] irqen_q, irqen_d;
    logic                  irq_q;
`endif

    always_comb begin
        addr_hit    = 1'b0;
        rd_data     = '0;
        sel_ctrl    = 1'b0;
        sel_inhibit = 1'b0;
        sel_ovf     = 1'b0;
        sel_lo      = '0;
        sel_hi      = '0;
        sel_evt     = '0;
`ifdef PERF_OVF_IRQ_EN
        sel_irqen   = 1'b0;
`endif
        if (csr_addr_i == PERF_CTRL) begin
            addr_hit = 1'b1;
            sel_ctrl = 1'b1;
            rd_data  = 32'(ctrl_q);
        end
        if (csr_addr_i == PERF_INHIBIT) begin
            addr_hit    = 1'b1;
            sel_inhibit = 1'b1;
            rd_data     = 32'(inhibit_q);
        end
        if (csr_addr_i == PERF_OVF) begin
            addr_hit = 1'b1;
            sel_ovf  = 1'b1;
            rd_data  = 32'(ovf_q);
        end
`ifdef PERF_OVF_IRQ_EN
        if (csr_addr_i == PERF_IRQEN) begin
            addr_hit  = 1'b1;
            sel_irqen = 1'b1;
            rd_data   = 32'(irqen_q);
        end
`endif
        for (int i = 0; i < N_COUNTERS; i++) begin
            if (csr_addr_i == PERF_CNT_LO + 12'(i)) begin
                addr_hit  = 1'b1;
                sel_lo[i] = 1'b1;
                rd_data   = cnt_lo[i];
            end
            if ((CNT_WIDTH > 32) && (csr_addr_i == PERF_CNT_HI + 12'(i))) begin
                addr_hit  = 1'b1;
                sel_hi[i] = 1'b1;
                rd_data   = cnt_hi[i];
            end
            if (csr_addr_i == PERF_EVTSEL + 12'(i)) begin
                addr_hit   = 1'b1;
                sel_evt[i] = 1'b1;
                rd_data    = 32'(evtsel[i]);
            end
        end
    end

    assign csr_hit_o   = csr_access_i & addr_hit;
    assign csr_rdata_o = csr_hit_o ? rd_data : '0;

    // The read mux already holds the addressed register, so it is the RMW "old" value.
    assign csr_we        = csr_hit_o & (csr_op_i != CSR_OP_NONE);
    assign wr_val        = perf_csr_apply(csr_op_i, csr_rdata_o, csr_wdata_i);
    assign unused_wr_val = ^wr_val;

    for (genvar i = 0; i < N_COUNTERS; i++) begin : g_slice
        riscv_perf_cnt_slice #(
            .CNT_WIDTH (CNT_WIDTH),
            .N_EVENTS  (N_EVENTS),
            .EVT_SEL_W (EVT_SEL_W)
        ) u_slice (
            .clk        (clk),
            .rst_n      (rst_n),
            .count_en_i (ctrl_q[CTRL_EN_BIT] & ~inhibit_q[i]),
            .sat_i      (ctrl_q[CTRL_SAT_BIT]),
            .evt_i      (evt_i),
            .lo_we_i    (csr_we & sel_lo[i]),
            .hi_we_i    (csr_we & sel_hi[i]),
            .sel_we_i   (csr_we & sel_evt[i]),
            .wdata_i    (wr_val),
            .cnt_lo_o   (cnt_lo[i]),
            .cnt_hi_o   (cnt_hi[i]),
            .evtsel_o   (evtsel[i]),
            .ovf_set_o  (ovf_set[i])
        );
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        inhibit_d = inhibit_q;
        ovf_d     = ovf_q;
        if (csr_we && sel_ctrl)    ctrl_d    = wr_val[1:0];
        if (csr_we && sel_inhibit) inhibit_d = wr_val[N_COUNTERS-1:0];
        if (csr_we && sel_ovf)     ovf_d     = wr_val[N_COUNTERS-1:0];
        // Hardware overflow set beats a same-cycle software clear.
        ovf_d = ovf_d | ovf_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= 2'b11;
            inhibit_q <= '0;
            ovf_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            inhibit_q <= inhibit_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;

`ifdef PERF_OVF_IRQ_EN
    assign irqen_d = (csr_we && sel_irqen) ? wr_val[N_COUNTERS-1:0] : irqen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irqen_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            irqen_q <= irqen_d;
            irq_q   <= |(ovf_q & irqen_q);
        end
    end

    assign perf_irq_o = irq_q;
`else
    assign perf_irq_o = 1'b0;
`endif

endmodule
